// File: rtl/id_stage_pipe_if.sv
// Bundle of the decode stage's upstream, write-back and downstream signals.
// The master side drives instructions and write-backs; the slave side is the stage.
interface id_stage_pipe_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_inst;
  logic            flush;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [2:0]      out_fn3;
  logic [6:0]      out_fn7;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [XLEN-1:0] out_r1;
  logic [XLEN-1:0] out_r2;
  logic [XLEN-1:0] out_imm;
  logic            out_illegal;

  modport master (
    output in_valid, in_pc, in_inst, flush, wb_en, wb_rd, wb_data, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_fn3, out_fn7, out_rd, out_rs1,
           out_rs2, out_r1, out_r2, out_imm, out_illegal
  );

  modport slave (
    input  in_valid, in_pc, in_inst, flush, wb_en, wb_rd, wb_data, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_fn3, out_fn7, out_rd, out_rs1,
           out_rs2, out_r1, out_r2, out_imm, out_illegal
  );
endinterface

// File: rtl/id_stage_pipe.sv
// RV32 decode stage: register file, field/immediate decode, write-back bypass,
// load-use interlock and the ID/EX register with valid/ready handshake and flush.
module id_stage_pipe #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter bit          BYPASS = 1'b1
) (
  input logic            clk,
  input logic            rst,
  id_stage_pipe_if.slave bus_io
);

  localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;

  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      fn3;
    logic [6:0]      fn7;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            use1;
    logic            use2;
    logic [XLEN-1:0] r1;
    logic [XLEN-1:0] r2;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } idex_t;

  function automatic logic idx_ok(input logic [4:0] idx);
    return 32'(idx) < NREG;
  endfunction

  logic [31:0]     inst;
  logic [6:0]      opcode;
  logic [4:0]      rd, rs1, rs2;
  logic            legal_op, rd_used, rs1_used, rs2_used, illegal;
  logic            use1, use2;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm, r1, r2;
  logic            wb_ok, hz, adv, in_ready, accept;
  logic [XLEN-1:0] rf_q [NREG];
  idex_t           idex_d, idex_q;

  assign inst   = bus_io.in_inst;
  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];

  always_comb begin
    legal_op = 1'b0;
    rd_used  = 1'b0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    imm32    = '0;
    unique case (opcode)
      OpOp: begin
        legal_op = 1'b1; rd_used = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
      end
      OpImm, OpLoad, OpJalr, OpSystem: begin
        legal_op = 1'b1; rd_used = 1'b1; rs1_used = 1'b1;
        imm32    = {{20{inst[31]}}, inst[31:20]};
      end
      OpStore: begin
        legal_op = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
        imm32    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OpBranch: begin
        legal_op = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
        imm32    = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OpLui, OpAuipc: begin
        legal_op = 1'b1; rd_used = 1'b1;
        imm32    = {inst[31:12], 12'b0};
      end
      OpJal: begin
        legal_op = 1'b1; rd_used = 1'b1;
        imm32    = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OpFence: begin
        legal_op = 1'b1; rd_used = 1'b1; rs1_used = 1'b1;
      end
      default: ;
    endcase
  end

  assign imm     = XLEN'($signed(imm32));
  assign illegal = !legal_op || (rd_used && !idx_ok(rd)) || (rs1_used && !idx_ok(rs1)) ||
                   (rs2_used && !idx_ok(rs2));
  // An illegal instruction reads nothing, so it can never interlock.
  assign use1    = rs1_used && !illegal;
  assign use2    = rs2_used && !illegal;

  assign wb_ok = bus_io.wb_en && (bus_io.wb_rd != 5'd0) && idx_ok(bus_io.wb_rd);

  always_comb begin
    r1 = '0;
    r2 = '0;
    if (use1 && rs1 != 5'd0) begin
      if (BYPASS && wb_ok && bus_io.wb_rd == rs1) r1 = bus_io.wb_data;
      else                                        r1 = rf_q[rs1[AW-1:0]];
    end
    if (use2 && rs2 != 5'd0) begin
      if (BYPASS && wb_ok && bus_io.wb_rd == rs2) r2 = bus_io.wb_data;
      else                                        r2 = rf_q[rs2[AW-1:0]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) rf_q[i] <= '0;
    end else if (wb_ok) begin
      rf_q[bus_io.wb_rd[AW-1:0]] <= bus_io.wb_data;
    end
  end

  assign hz = idex_q.valid && idex_q.opcode == OpLoad && idex_q.rd != 5'd0 &&
              ((use1 && rs1 == idex_q.rd) || (use2 && rs2 == idex_q.rd));
  assign adv      = !idex_q.valid || bus_io.out_ready;
  assign in_ready = adv && !hz && !bus_io.flush;
  assign accept   = bus_io.in_valid && in_ready;

  always_comb begin
    idex_d = idex_q;
    if (bus_io.flush) begin
      idex_d.valid = 1'b0;
    end else if (accept) begin
      idex_d.valid   = 1'b1;
      idex_d.pc      = bus_io.in_pc;
      idex_d.opcode  = opcode;
      idex_d.fn3     = inst[14:12];
      idex_d.fn7     = inst[31:25];
      idex_d.rd      = rd;
      idex_d.rs1     = rs1;
      idex_d.rs2     = rs2;
      idex_d.use1    = use1;
      idex_d.use2    = use2;
      idex_d.r1      = r1;
      idex_d.r2      = r2;
      idex_d.imm     = imm;
      idex_d.illegal = illegal;
    end else if (bus_io.out_ready) begin
      idex_d.valid = 1'b0;
    end else if (idex_q.valid) begin
      // Held operands would go stale if their register is written while EX stalls.
      if (wb_ok && idex_q.use1 && bus_io.wb_rd == idex_q.rs1) idex_d.r1 = bus_io.wb_data;
      if (wb_ok && idex_q.use2 && bus_io.wb_rd == idex_q.rs2) idex_d.r2 = bus_io.wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idex_q <= '0;
    else     idex_q <= idex_d;
  end

  assign bus_io.in_ready    = in_ready;
  assign bus_io.out_valid   = idex_q.valid;
  assign bus_io.out_pc      = idex_q.pc;
  assign bus_io.out_opcode  = idex_q.opcode;
  assign bus_io.out_fn3     = idex_q.fn3;
  assign bus_io.out_fn7     = idex_q.fn7;
  assign bus_io.out_rd      = idex_q.rd;
  assign bus_io.out_rs1     = idex_q.rs1;
  assign bus_io.out_rs2     = idex_q.rs2;
  assign bus_io.out_r1      = idex_q.r1;
  assign bus_io.out_r2      = idex_q.r2;
  assign bus_io.out_imm     = idex_q.imm;
  assign bus_io.out_illegal = idex_q.illegal;

endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Parametrised instruction-decode stage for the RV32 pipeline. It contains the architectural register file, field extraction, immediate generation for all RV32I formats, write-back bypass, load-use interlock and the ID/EX pipeline register with a valid/ready handshake and flush. It sits between the IF/ID register and EX. Opcode, fn3 and fn7 are passed through to the controller in EX.

## Interface
- XLEN, 32: datapath width; register and immediate width.
- NREG, 32: architectural registers (32 = RV32I, 16 = RV32E).
- BYPASS, 1: 1 = same-cycle write-back forwarding into reads; 0 = read raw array.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  IF/ID holds an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_pc  in  XLEN  instruction PC.
- in_inst  in  32  instruction word.
- flush  in  1  kill the held instruction and drop the input this cycle.
- wb_en, wb_rd[4:0], wb_data[XLEN]  in  register write port.
- out_valid  out  1  ID/EX register holds a valid instruction.
- out_ready  in  1  EX accepts the instruction this cycle.
- out_pc[XLEN], out_opcode[7], out_fn3[3], out_fn7[7], out_rd[5], out_rs1[5], out_rs2[5]  out  registered fields.
- out_r1, out_r2, out_imm  out  XLEN  registered operands and sign-extended immediate.
- out_illegal  out  1  registered illegal-instruction flag.

## Operation
- Decode is combinational on in_inst:
  - opcode = [6:0], rd = [11:7], fn3 = [14:12], rs1 = [19:15], rs2 = [24:20], fn7 = [31:25].
- Immediates, all sign-extended from inst[31] to XLEN:
  - I (0000011, 0010011, 1100111, 1110011): inst[31:20].
  - S (0100011): {[31:25],[11:7]}.
  - B (1100011): {[31],[7],[30:25],[11:8],0}.
  - U (0110111, 0010111): {[31:12], 12'b0}.
  - J (1101111): {[31],[19:12],[20],[30:21],0}.
  - All others: 0.
- Register use:
  - rs1 is used by every legal opcode except LUI, AUIPC and JAL.
  - rs2 is used only by 0110011, 0100011 and 1100011.
- Illegal instruction: opcode is outside {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 0001111, 1110011}, or any used rd/rs1/rs2 index is ≥ NREG. An illegal instruction uses no registers and still flows through the stage with out_illegal=1.
- Register file:
  - NREG×XLEN with combinational read and a write on the edge when wb_en && wb_rd≠0 && wb_rd<NREG.
  - x0 always reads 0. Writes to x0 or to an out-of-range index are ignored.
  - With BYPASS=1, a read whose index equals wb_rd while the write is enabled and valid returns wb_data.
- Load-use hazard (hz): out_valid && out_opcode==0000011 && out_rd≠0, and out_rd equals a used rs1/rs2 of the input instruction.
- Handshake:
  - adv = !out_valid || out_ready.
  - in_ready = adv && !hz && !flush.
- ID/EX register update, in priority order:
  1. flush: out_valid←0.
  2. in_valid && in_ready: capture all fields; out_valid←1.
  3. out_ready (covers hz and !in_valid): out_valid←0. This inserts the bubble.
  4. Otherwise hold.
- Stall refresh: while holding (out_valid && !out_ready && !flush), a valid write whose wb_rd equals out_rs1 (used) or out_rs2 (used) loads wb_data into out_r1 or out_r2. This applies regardless of BYPASS.
- Write-back writes happen during flush and stalls.

## Timing
- Reset: every out_* = 0 and all registers = 0. in_ready follows its equation (1 after reset unless flush).
- Decode-to-output latency is 1 cycle. Throughput is 1 instruction/cycle without hazards.
- in_ready depends combinationally on out_ready, flush and in_inst. There is no path from in_valid to in_ready.
- A load followed by a dependent instruction costs exactly 1 bubble cycle, provided EX is ready.
- A dependence on rd=x0 never stalls.
- A write in the same cycle as a read is visible that cycle only when BYPASS=1. Otherwise it is visible next cycle.
- rst asserted mid-stall clears out_valid immediately (asynchronous). The first accept is possible on the first edge after deassertion.

## Test plan
- Reset, then wb x5=0x1234, then issue ADDI x6,x5,-1 (0xFFF28313) → out_r1=0x1234, out_imm=0xFFFFFFFF, out_valid 1 cycle after accept.
- LW x7,0(x1) then ADD x8,x7,x2 with out_ready=1 → in_ready=0 for one cycle, one out_valid=0 bubble, ADD issued next cycle. Repeat with LW to x0 → no bubble.
- Same-cycle wb x3=0xAA and SW x3,4(x2) read → BYPASS=1: out_r2=0xAA. BYPASS=0: old value. Check out_imm=4.
- Hold out_ready=0 with ADD x4,x9,x9 in the ID/EX register, then wb x9=0x55 → out_r1=out_r2=0x55 on release. Check that flush in the same cycle clears out_valid.
- NREG=16: ADD x20,x1,x1 → out_illegal=1. Opcode 0x7F → out_illegal=1, no stall. Write to x17 ignored.
- Immediates: JAL 0x8000006F → out_imm=0xFFF00000. BEQ 0x80000063 → 0xFFFFF000. LUI 0xABCDE0B7 → 0xABCDE000.
